// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Boot loader that turns a framed, checksummed byte stream into
//            instruction-memory writes and releases the CPU once verified.
// Revision : 1.0
// ============================================================================
module program_loader #(
    parameter int INSTR_W = 19,
    parameter int ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int          BYTES       = (INSTR_W + 7) / 8;
    localparam int          BCNT_W      = (BYTES > 2) ? $clog2(BYTES) : 1;
    localparam logic [32:0] c_max_words = 33'd1 << ADDR_W;
    localparam logic [BCNT_W-1:0] c_last_byte = BCNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_RUN     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_len;
    logic [15:0]         r_word_idx;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [7:0]          r_xor;
    // Only the low INSTR_W-8 bits of earlier bytes can survive into a word.
    logic [INSTR_W-9:0]  r_shift;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [INSTR_W-1:0]  r_imem_wdata;
    logic                r_cpu_rst_n;
    logic                r_done;
    logic                r_error;

    logic                w_busy;
    logic                w_accept;
    logic                w_start_ok;
    logic                w_last_byte;
    logic                w_last_word;
    logic [15:0]         w_len;
    logic [INSTR_W-1:0]  w_word;

    assign w_busy      = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                         (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign w_accept    = w_busy && in_valid;
    assign w_start_ok  = start && !w_busy;
    assign w_last_byte = (r_byte_cnt == c_last_byte);
    assign w_last_word = (r_word_idx == (r_len - 16'd1));
    assign w_len       = {r_len[15:8], in_data};
    assign w_word      = {r_shift, in_data};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if ({17'd0, w_len} > c_max_words) w_state_next = S_ERR;
                    else if (w_len == 16'd0)          w_state_next = S_CHECK;
                    else                              w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_accept && w_last_byte && w_last_word) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_state_next = (in_data == r_xor) ? S_RUN : S_ERR;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_len        <= 16'd0;
            r_word_idx   <= 16'd0;
            r_byte_cnt   <= '0;
            r_xor        <= 8'd0;
            r_shift      <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst_n  <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_imem_we   <= 1'b0;
            // Status flags track the state being entered on this edge.
            r_done      <= (w_state_next == S_RUN);
            r_cpu_rst_n <= (w_state_next == S_RUN);
            r_error     <= (w_state_next == S_ERR);
            if (w_start_ok) begin
                r_xor      <= 8'd0;
                r_byte_cnt <= '0;
                r_word_idx <= 16'd0;
            end else if (w_accept) begin
                r_xor <= r_xor ^ in_data;
                case (r_state)
                    S_LEN_HI: r_len[15:8] <= in_data;
                    S_LEN_LO: r_len[7:0]  <= in_data;
                    S_PAYLOAD: begin
                        r_shift <= w_word[INSTR_W-9:0];
                        if (w_last_byte) begin
                            r_byte_cnt   <= '0;
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= ADDR_W'(r_word_idx);
                            r_imem_wdata <= w_word;
                            r_word_idx   <= r_word_idx + 16'd1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = w_busy;
    assign busy       = w_busy;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Randomised frame loader bench against a frame-level reference.
// Revision : 1.0
// ============================================================================
module tb_program_loader;

    localparam int INSTR_W = 19;
    localparam int ADDR_W  = 12;
    localparam int BYTES   = (INSTR_W + 7) / 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         in_data = 8'd0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_rst_n;
    logic               busy;
    logic               done;
    logic               error;

    program_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0]  exp_addr_q[$];
    logic [INSTR_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0]  log_addr[$];
    logic [INSTR_W-1:0] log_data[$];
    logic [7:0]         frame[$];
    bit                 exp_ok;
    int                 n_send;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: decode the whole frame into expected writes and verdict.
    task automatic model();
        int n;
        logic [7:0] x;
        logic [8*BYTES-1:0] w;
        n = {frame[0], frame[1]};
        if (n > (1 << ADDR_W)) begin
            exp_ok = 1'b0;
            n_send = 2;
            return;
        end
        x = frame[0] ^ frame[1];
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int b = 0; b < BYTES; b++) begin
                w = (w << 8) | (8*BYTES)'(frame[2 + BYTES*i + b]);
                x = x ^ frame[2 + BYTES*i + b];
            end
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(w[INSTR_W-1:0]);
        end
        n_send = 3 + BYTES*n;
        exp_ok = (frame[2 + BYTES*n] == x);
    endtask

    task automatic make_frame(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        x = frame[0] ^ frame[1];
        for (int i = 0; i < BYTES*n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        frame.push_back(x);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("after_start", {cpu_rst_n, done, error, busy}, 4'b0001);
    endtask

    task automatic send_bytes(input int count, input int gap_max, input bit noise);
        int tmo;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                start    = noise ? 1'($urandom) : 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            start    = noise ? 1'($urandom) : 1'b0;
            tmo = 0;
            while (!in_ready && tmo < 50) begin
                @(posedge clk); #1;
                tmo++;
            end
            if (!in_ready) begin
                check("ready_timeout", {63'd0, in_ready}, 64'd1);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic run_load(input int gap_max, input bit noise);
        model();
        send_bytes(n_send, gap_max, noise);
        check("outcome", {done, error, cpu_rst_n, busy, in_ready},
              exp_ok ? 5'b10100 : 5'b01000);
        @(negedge clk);
        check("writes_drained", 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("ready_eq_busy", {63'd0, in_ready}, {63'd0, busy});
            check("run_flag_pair", {63'd0, cpu_rst_n}, {63'd0, done});
            if (imem_we) begin
                if (exp_addr_q.size() == 0) begin
                    check("spurious_we", {63'd0, imem_we}, 64'd0);
                end else begin
                    check("we_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
                    check("we_data", 64'(imem_wdata), 64'(exp_data_q.pop_front()));
                end
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        check("reset_outputs",
              {in_ready, imem_we, 64'(imem_addr), 64'(imem_wdata), cpu_rst_n, busy, done, error},
              '0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Two-word reference frame.
        log_addr.delete(); log_data.delete();
        frame = {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
        do_start();
        run_load(0, 1'b0);
        check("lit_n_writes", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            check("lit_addr0", 64'(log_addr[0]), 64'd0);
            check("lit_data0", 64'(log_data[0]), 64'h12345);
            check("lit_addr1", 64'(log_addr[1]), 64'd1);
            check("lit_data1", 64'(log_data[1]), 64'h7FFFF);
        end
        check("lit_done", {cpu_rst_n, done, busy}, 3'b110);

        // Bad checksum: words still written, then error.
        log_addr.delete(); log_data.delete();
        frame[8] = 8'h63;
        do_start();
        run_load(0, 1'b0);
        check("bad_csum_writes", 64'(log_addr.size()), 64'd2);
        check("bad_csum_flags", {error, cpu_rst_n, done, in_ready}, 4'b1000);

        // Empty image.
        log_addr.delete(); log_data.delete();
        frame = {8'h00, 8'h00, 8'h00};
        do_start();
        run_load(0, 1'b0);
        check("empty_no_we", 64'(log_addr.size()), 64'd0);
        check("empty_done", {63'd0, done}, 64'd1);

        // Back-pressure on the two-word frame.
        frame = {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
        do_start();
        run_load(5, 1'b0);

        // Length overflow.
        log_addr.delete(); log_data.delete();
        frame = {8'h10, 8'h01};
        do_start();
        run_load(0, 1'b0);
        check("ovf_no_we", 64'(log_addr.size()), 64'd0);

        // Asynchronous reset after four payload bytes, then reload.
        frame = {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
        do_start();
        model();
        send_bytes(6, 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {in_ready, imem_we, 64'(imem_addr), 64'(imem_wdata), cpu_rst_n, busy, done, error},
              '0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        do_start();
        run_load(2, 1'b0);

        // Reload from RUN with start pulses while busy.
        check("pre_reload_run", {63'd0, done}, 64'd1);
        do_start();
        run_load(3, 1'b1);

        // Random frames.
        for (int t = 0; t < 10; t++) begin
            make_frame($urandom_range(1, 24), ($urandom_range(0, 3) == 0));
            do_start();
            run_load($urandom_range(0, 3), 1'($urandom));
        end

        // Largest legal image: addresses reach the top without wrapping.
        log_addr.delete(); log_data.delete();
        make_frame(1 << ADDR_W, 1'b0);
        do_start();
        run_load(0, 1'b0);
        check("max_n_writes", 64'(log_addr.size()), 64'd4096);
        if (log_addr.size() > 0)
            check("max_last_addr", 64'(log_addr[log_addr.size()-1]), 64'hFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
